uart_rx_fifo: RTL

Receive buffer that sits directly downstream of the UART receiver. It detects each frame-complete pulse on `RxDone` and pushes the parallel byte on `RxData` into a circular FIFO. Host logic drains the FIFO through a read-enable interface. The block also reports occupancy and a sticky overrun flag, so the receiver never has to stall.

---
 rtl/uart_rx_fifo.sv | 118 +++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: synchronises RxDone, pushes one byte per frame, drains via RdEn.
// Define UART_RX_FIFO_FWFT_EN for first-word fall-through reads; the default is a registered read.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [7:0]            RxData,
  input  logic                  RxDone,
  input  logic                  RdEn,
  input  logic                  OvrClr,
  output logic [7:0]            RdData,
  output logic                  RdValid,
  output logic                  Empty,
  output logic                  Full,
  output logic [DEPTH_LOG2:0]   Count,
  output logic                  Overrun
);

  localparam int                     DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]    COUNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]    COUNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0]  PTR_ONE    = DEPTH_LOG2'(1);

  logic                    s1_q, s1_d;
  logic                    s2_q, s2_d;
  logic                    s3_q, s3_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    overrun_q, overrun_d;
  logic [7:0]              mem_q [DEPTH];

  logic                    push;
  logic                    push_ok;
  logic                    pop;

  assign Empty   = (count_q == '0);
  assign Full    = (count_q == COUNT_FULL);
  assign Count   = count_q;
  assign Overrun = overrun_q;

  always_comb begin
    s1_d      = RxDone;
    s2_d      = s1_q;
    s3_d      = s2_q;
    push      = s2_q & ~s3_q;
    pop       = RdEn & ~Empty;
    // A push into a full FIFO only fits if the same cycle frees a slot.
    push_ok   = push & (~Full | pop);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase
    if (OvrClr)                overrun_d = 1'b0;
    if (push & Full & ~pop)    overrun_d = 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge Clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= RxData;
  end

`ifdef UART_RX_FIFO_FWFT_EN
  assign RdData  = Empty ? 8'h00 : mem_q[rd_ptr_q];
  assign RdValid = ~Empty;
`else
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d;

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = pop;
    if (pop) rd_data_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign RdData  = rd_data_q;
  assign RdValid = rd_valid_q;
`endif

endmodule
